// File: rtl/dual_slope_ctrl.sv
// Dual-slope ADC sequencer: auto-zero, fixed run-up, reference run-down with a BCD count.
// Optional AUTOZERO_EN macro adds the AZ phase; undefined, IDLE and DONE go straight to RUNUP.
module dual_slope_ctrl #(
    parameter int DIGITS = 3,
    parameter int T_INT  = 100,
    parameter int T_AZ   = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  cont,
    input  logic                  vint_z,
    input  logic                  vin_neg,
    output logic                  sw_az,
    output logic                  sw_in,
    output logic                  sw_ref,
    output logic                  ref_neg,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   result,
    output logic                  neg,
    output logic                  ovr,
    output logic                  valid
);

    localparam int BW      = 4 * DIGITS;
    localparam int TMR_MAX = (T_INT > T_AZ) ? T_INT : T_AZ;
    localparam int TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;
    localparam logic [TW-1:0] INT_LAST  = TW'(T_INT - 1);
    localparam logic [BW-1:0] ALL_NINES = {DIGITS{4'h9}};

    if (DIGITS < 1) begin : g_bad_digits
        $error("dual_slope_ctrl: DIGITS must be at least 1");
    end
    if (T_INT < 1) begin : g_bad_tint
        $error("dual_slope_ctrl: T_INT must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        AZ    = 3'd1,
        RUNUP = 3'd2,
        RUNDN = 3'd3,
        DONE  = 3'd4
    } state_t;

`ifdef AUTOZERO_EN
    localparam logic [TW-1:0] AZ_LAST = TW'(T_AZ - 1);
    localparam state_t FIRST = AZ;
`else
    localparam state_t FIRST = RUNUP;
`endif

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            sign_q, sign_d;
    logic            ref_neg_q, ref_neg_d;
    logic [BW-1:0]   result_q, result_d;
    logic            neg_q, neg_d;
    logic            ovr_q, ovr_d;
    logic            sw_az_q, sw_az_d;
    logic            sw_in_q, sw_in_d;
    logic            sw_ref_q, sw_ref_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;

    // Decimal increment: each digit wraps 9->0 and carries into the next one up.
    function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bcd_d     = bcd_q;
        sign_d    = sign_q;
        ref_neg_d = ref_neg_q;
        result_d  = result_q;
        neg_d     = neg_q;
        ovr_d     = ovr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FIRST;
                    timer_d = '0;
                    bcd_d   = '0;
                end
            end
`ifdef AUTOZERO_EN
            AZ: begin
                if (timer_q == AZ_LAST) begin
                    state_d = RUNUP;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
`endif
            RUNUP: begin
                if (timer_q == INT_LAST) begin
                    // Reference polarity is always opposite to the integrated input.
                    state_d   = RUNDN;
                    timer_d   = '0;
                    bcd_d     = '0;
                    sign_d    = vin_neg;
                    ref_neg_d = !vin_neg;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RUNDN: begin
                if (vint_z) begin
                    state_d  = DONE;
                    result_d = bcd_q;
                    neg_d    = sign_q;
                    ovr_d    = 1'b0;
                end else if (bcd_q == ALL_NINES) begin
                    state_d  = DONE;
                    result_d = ALL_NINES;
                    neg_d    = sign_q;
                    ovr_d    = 1'b1;
                end else begin
                    bcd_d = bcd_inc(bcd_q);
                end
            end
            DONE: begin
                timer_d = '0;
                bcd_d   = '0;
                state_d = cont ? FIRST : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they toggle on the state-change edge.
        sw_az_d  = (state_d == IDLE) || (state_d == AZ) || (state_d == DONE);
        sw_in_d  = (state_d == RUNUP);
        sw_ref_d = (state_d == RUNDN);
        busy_d   = (state_d != IDLE);
        valid_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bcd_q     <= '0;
            sign_q    <= 1'b0;
            ref_neg_q <= 1'b0;
            result_q  <= '0;
            neg_q     <= 1'b0;
            ovr_q     <= 1'b0;
            sw_az_q   <= 1'b1;
            sw_in_q   <= 1'b0;
            sw_ref_q  <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bcd_q     <= bcd_d;
            sign_q    <= sign_d;
            ref_neg_q <= ref_neg_d;
            result_q  <= result_d;
            neg_q     <= neg_d;
            ovr_q     <= ovr_d;
            sw_az_q   <= sw_az_d;
            sw_in_q   <= sw_in_d;
            sw_ref_q  <= sw_ref_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
        end
    end

    assign sw_az   = sw_az_q;
    assign sw_in   = sw_in_q;
    assign sw_ref  = sw_ref_q;
    assign ref_neg = ref_neg_q;
    assign busy    = busy_q;
    assign result  = result_q;
    assign neg     = neg_q;
    assign ovr     = ovr_q;
    assign valid   = valid_q;

endmodule

// File: tb/tb_dual_slope_ctrl.sv
// Directed bench for dual_slope_ctrl with DIGITS=3, T_INT=10, T_AZ=4.
module tb_dual_slope_ctrl;

    localparam int DIGITS = 3;
    localparam int TINT   = 10;
`ifdef AUTOZERO_EN
    localparam int TAZ      = 4;
    localparam int LAT37    = 52;
    localparam int PERIOD20 = 36;
`else
    localparam int TAZ      = 0;
    localparam int LAT37    = 48;
    localparam int PERIOD20 = 32;
`endif
    localparam int LIM = TAZ + TINT + 1100;

    logic                clk;
    logic                rstn;
    logic                start;
    logic                cont;
    logic                vint_z;
    logic                vin_neg;
    logic                sw_az;
    logic                sw_in;
    logic                sw_ref;
    logic                ref_neg;
    logic                busy;
    logic [4*DIGITS-1:0] result;
    logic                neg;
    logic                ovr;
    logic                valid;

    int checks   = 0;
    int failures = 0;

    dual_slope_ctrl #(
        .DIGITS (DIGITS),
        .T_INT  (TINT),
        .T_AZ   (4)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .cont    (cont),
        .vint_z  (vint_z),
        .vin_neg (vin_neg),
        .sw_az   (sw_az),
        .sw_in   (sw_in),
        .sw_ref  (sw_ref),
        .ref_neg (ref_neg),
        .busy    (busy),
        .result  (result),
        .neg     (neg),
        .ovr     (ovr),
        .valid   (valid)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // Runs one conversion from IDLE. n<0 keeps vint_z low (overrange).
    // Returns at the cycle where valid is seen (or after LIM cycles with lat=-1).
    task automatic convert(input int n, input logic vneg, output int lat, output int az_cnt,
                           output int in_cnt, output int ref_cnt, output int overlap,
                           output logic rn);
        lat = -1; az_cnt = 0; in_cnt = 0; ref_cnt = 0; overlap = 0; rn = 1'bx;
        start   = 1'b1;
        vin_neg = vneg;
        vint_z  = 1'b0;
        step_clk();
        start = 1'b0;
        for (int j = 0; j < LIM; j++) begin
            if (valid) begin
                lat = j;
                break;
            end
            if (sw_az)  az_cnt++;
            if (sw_in)  in_cnt++;
            if (sw_ref) ref_cnt++;
            if (int'(sw_az) + int'(sw_in) + int'(sw_ref) > 1) overlap++;
            if (j == TAZ + TINT) rn = ref_neg;
            vint_z = (n >= 0 && j == TAZ + TINT + n);
            step_clk();
        end
        vint_z = 1'b0;
    endtask

    // driver for continuous mode and scoreboard-style bookkeeping
    int   lat, az_c, in_c, ref_c, ovl;
    logic rn;
    int   nv, last_v, base;

    initial begin
        rstn = 1'b0; start = 1'b0; cont = 1'b0; vint_z = 1'b0; vin_neg = 1'b0;
        repeat (4) begin
            step_clk();
            start   = 1'($urandom_range(0, 1));
            cont    = 1'($urandom_range(0, 1));
            vint_z  = 1'($urandom_range(0, 1));
            vin_neg = 1'($urandom_range(0, 1));
        end
        check("rst_sw_az", sw_az, 1);
        check("rst_sw_in", sw_in, 0);
        check("rst_sw_ref", sw_ref, 0);
        check("rst_ref_neg", ref_neg, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 12'h000);
        check("rst_neg", neg, 0);
        check("rst_ovr", ovr, 0);
        check("rst_valid", valid, 0);
        start = 1'b0; cont = 1'b0; vint_z = 1'b0; vin_neg = 1'b0;
        rstn = 1'b1;
        repeat (5) step_clk();
        check("idle_busy", busy, 0);
        check("idle_sw_az", sw_az, 1);

        // positive reading, N=37
        convert(37, 1'b0, lat, az_c, in_c, ref_c, ovl, rn);
        check("pos_latency", lat, LAT37);
        check("pos_az_cycles", az_c, TAZ);
        check("pos_in_cycles", in_c, 10);
        check("pos_ref_cycles", ref_c, 38);
        check("pos_overlap", ovl, 0);
        check("pos_ref_neg", rn, 1);
        check("pos_result", result, 12'h037);
        check("pos_neg", neg, 0);
        check("pos_ovr", ovr, 0);
        check("pos_busy_at_valid", busy, 1);
        step_clk();
        check("pos_valid_pulse", valid, 0);
        check("pos_busy_after", busy, 0);
        check("pos_result_held", result, 12'h037);

        // negative input, immediate zero crossing
        convert(0, 1'b1, lat, az_c, in_c, ref_c, ovl, rn);
        check("zero_latency", lat, TAZ + 11);
        check("zero_ref_neg", rn, 0);
        check("zero_result", result, 12'h000);
        check("zero_neg", neg, 1);
        check("zero_ovr", ovr, 0);
        step_clk();

        // crossing exactly at all nines is a valid reading
        convert(999, 1'b0, lat, az_c, in_c, ref_c, ovl, rn);
        check("n999_latency", lat, TAZ + TINT + 1000);
        check("n999_result", result, 12'h999);
        check("n999_ovr", ovr, 0);
        check("n999_neg", neg, 0);
        step_clk();

        // overrange
        convert(-1, 1'b1, lat, az_c, in_c, ref_c, ovl, rn);
        check("ovr_latency", lat, TAZ + TINT + 1000);
        check("ovr_ref_cycles", ref_c, 1000);
        check("ovr_result", result, 12'h999);
        check("ovr_flag", ovr, 1);
        step_clk();
        check("ovr_held", ovr, 1);

        // next reading clears overrange
        convert(5, 1'b0, lat, az_c, in_c, ref_c, ovl, rn);
        check("n5_result", result, 12'h005);
        check("n5_ovr", ovr, 0);
        step_clk();

        // continuous mode, N=20, stray start pulses, cont dropped mid-conversion
        cont  = 1'b1;
        start = 1'b1;
        step_clk();
        start  = 1'b0;
        nv     = 0;
        last_v = -1;
        base   = 0;
        for (int j = 0; j < 2000 && nv < 4; j++) begin
            if (valid) begin
                if (last_v >= 0) check("cont_period", j - last_v, PERIOD20);
                else             check("cont_first_lat", j, TAZ + TINT + 21);
                check("cont_result", result, 12'h020);
                last_v = j;
                nv++;
                base = j + 1;
            end
            if (nv == 3 && j == base + 5) cont = 1'b0;
            start  = (j % 7 == 3) && !valid;
            vint_z = (j - base == TAZ + TINT + 20);
            step_clk();
        end
        start  = 1'b0;
        vint_z = 1'b0;
        check("cont_valid_count", nv, 4);
        check("cont_stop_busy", busy, 0);
        repeat (5) step_clk();
        check("cont_stays_idle", busy, 0);

        // asynchronous reset in the middle of run-down
        start = 1'b1;
        step_clk();
        start = 1'b0;
        repeat (TAZ + TINT + 5) step_clk();
        check("mid_in_rundn", sw_ref, 1);
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_sw_az", sw_az, 1);
        check("mid_rst_sw_ref", sw_ref, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_result", result, 12'h000);
        check("mid_rst_ref_neg", ref_neg, 0);
        step_clk();
        rstn = 1'b1;
        repeat (3) step_clk();
        check("mid_rst_idle", busy, 0);
        check("mid_rst_valid", valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
